data_memory_manager: RTL and testbench
======================================

# data_memory_manager

Byte-wide data memory with two memory-mapped I/O ports for the CPU's data path. Presents a 1024-entry × 8-bit RAM on a 10-bit address space. The top two addresses are a 4-bit input port (read-only, sign-extended onto the bus) and a 4-bit output port (write-only). Reads go onto a shared tri-state data bus, so `out_data` is high-Z whenever the block is not driving.

## Interface
Clock is `clk`, reset is `rst`; one clock; reset is synchronous and active-high.

Parameters (fixed localparams):
- `INPUT_PORT`, 10'h3FE, address of the input port.
- `OUTPUT_PORT`, 10'h3FF, address of the output port.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `in_write_en`  in  1  write strobe, sampled at rising edge.
- `in_read_en`  in  1  bus drive enable, combinational.
- `in_addr_write_en`  in  1  load address register from `in_addr`.
- `in_data`  in  8  write data.
- `in_addr`  in  10  address.
- `out_data`  out  8  tri-state read bus.
- `in_port`  in  4  external input port pins.
- `out_port`  out  4  external output port register.

## Operation
- State:
  - `addr_reg[9:0]`.
  - `in_port_reg[3:0]`.
  - `out_port_reg[3:0]`, which drives `out_port`.
  - `mem[0:1023][7:0]`.
- Effective address `ea` = `in_addr_write_en ? in_addr : addr_reg`.
- Rising edge, `rst`=1:
  - `addr_reg`, `in_port_reg` and `out_port_reg` are set to 0.
  - Memory is untouched.
  - No write occurs.
- Rising edge, `rst`=0:
  - `in_port_reg` <= `in_port`, every cycle, unconditionally.
  - If `in_addr_write_en`, then `addr_reg` <= `in_addr`.
  - If `in_write_en` and `ea`==`OUTPUT_PORT`, then `out_port_reg` <= `in_data[3:0]`. Memory is not written.
  - If `in_write_en` and `ea`==`INPUT_PORT`, the write is discarded with no state change.
  - If `in_write_en` at any other address, then `mem[ea]` <= `in_data`.
- Read (combinational from `addr_reg`):
  - `in_read_en`=0: `out_data` = 8'hZZ.
  - `addr_reg`==`OUTPUT_PORT`: 8'hZZ. The output port is not readable.
  - `addr_reg`==`INPUT_PORT`: `{{4{in_port_reg[3]}}, in_port_reg}`, i.e. sign-extended.
  - Otherwise: `mem[addr_reg]`.
- Uninitialized memory reads return X in simulation, unless the macro in Configuration is defined.

## Timing
- Write latency is 1 edge. Write and address load happen on the same edge, so the written value is visible on `out_data` immediately after that edge (write-through).
- Read data follows `addr_reg`. A new address passed via `in_addr` is visible 1 edge later. `in_read_en` gating is immediate (0 cycles).
- `in_port` changes appear on `out_data` only after the next rising edge. A pin change between edges does not alter `out_data`.
- `out_port`:
  - Reset value is 0.
  - Changes only on a rising edge with a write to `OUTPUT_PORT`.
  - Holds its value otherwise, including during writes to other addresses.
- `out_data` reset value: Z if `in_read_en`=0. Otherwise it shows the `mem[0]` contents, since `addr_reg`=0 after reset.
- Reset concurrent with `in_write_en`: reset wins; no memory or port write.
- Simultaneous read and write of the same address: `out_data` shows the old value before the edge and the new value after it.

## Configuration
- `DATA_MEMORY_MANAGER_MEM_INIT_EN`
  - Defined: all 1024 memory bytes are zero at time 0, via an initialization loop. Uninitialized reads return 8'h00.
  - Undefined (default): memory has no initialization. Uninitialized reads return X.
  - Port and reset behaviour are identical in both builds.

## Test plan
- Hold `in_addr_write_en`=1 and `in_read_en`=1 throughout.
- Write path:
  - `in_data`=8'h99, addr 0x3FE, `in_write_en`=1, 1 edge → `out_data`=X.
  - Then addr 0x00F, `in_write_en`=0, 1 edge → `out_data`=X.
  - Then `in_write_en`=1, 1 edge → `out_data`=8'h99.
- Read gating:
  - `in_write_en`=0, addr 0x3FE with `in_port`=X → `out_data`=X.
  - addr 0x3FF → 8'hZZ.
  - addr 0x00F with `in_read_en`=0 → 8'hZZ.
  - Then `in_read_en`=1, 1 edge → 8'h99.
- Input port:
  - `in_port`=4'b1100, addr 0x055, 1 edge → X.
  - addr 0x3FE, 1 edge → 8'hFC.
  - Change `in_port` to 4'b0001 without an edge → still 8'hFC.
  - Next edge → 8'h01.
- Output port:
  - `in_write_en`=1, `in_data`=8'h8C, addr 0x055, 1 edge → `out_port`=4'h0.
  - addr 0x3FF, 1 edge → `out_port`=4'hC.
  - Verify `mem[0x3FF]` is not readable: reading 0x3FF returns Z.
- Reset and address hold:
  - `rst`=1 for 1 edge with `in_write_en`=1 to 0x3FF → `out_port`=0, and memory is unchanged.
  - Load addr 0x00F, then `in_addr_write_en`=0, set `in_addr`=0x055, write 8'h5A → `mem[0x00F]`=8'h5A, and `out_data` shows 8'h5A.

Source files
------------

// File: rtl/data_memory_manager.sv
// Byte-wide data memory (1024 x 8) with a memory-mapped 4-bit input port at
// 0x3FE and a 4-bit output port at 0x3FF, read onto a shared tri-state bus.
//
// Ports:
//   clk              system clock, all state updates on the rising edge
//   rst              synchronous active-high reset
//   in_write_en      write strobe, sampled on the rising edge
//   in_read_en       bus drive enable, combinational
//   in_addr_write_en load the address register from in_addr
//   in_data[7:0]     write data
//   in_addr[9:0]     address
//   out_data[7:0]    tri-state read bus (Z when not driving)
//   in_port[3:0]     external input pins
//   out_port[3:0]    external output port register
//
// Optional build macro: DATA_MEMORY_MANAGER_MEM_INIT_EN zero-fills the memory
// at time 0; without it the memory starts uninitialized.

module data_memory_manager (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_write_en,
    input  logic       in_read_en,
    input  logic       in_addr_write_en,
    input  logic [7:0] in_data,
    input  logic [9:0] in_addr,
    output logic [7:0] out_data,
    input  logic [3:0] in_port,
    output logic [3:0] out_port
);

    localparam logic [9:0] INPUT_PORT  = 10'h3FE;
    localparam logic [9:0] OUTPUT_PORT = 10'h3FF;

    logic [9:0] addr_reg;
    logic [3:0] in_port_reg;
    logic [3:0] out_port_reg;
    logic [7:0] mem [0:1023];

    logic [9:0] ea;
    logic       wr_port;
    logic       wr_mem;
    logic       drive;
    logic [7:0] rd_data;

`ifdef DATA_MEMORY_MANAGER_MEM_INIT_EN
    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'h00;
        end
    end
`endif

    // The address being loaded this edge is also the write target, so a
    // write and an address load on the same edge land at the new address.
    assign ea      = in_addr_write_en ? in_addr : addr_reg;
    assign wr_port = in_write_en && (ea == OUTPUT_PORT);
    assign wr_mem  = in_write_en && (ea != OUTPUT_PORT)
                                 && (ea != INPUT_PORT);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg     <= 10'd0;
            in_port_reg  <= 4'd0;
            out_port_reg <= 4'd0;
        end else begin
            in_port_reg <= in_port;
            if (in_addr_write_en) begin
                addr_reg <= in_addr;
            end
            if (wr_port) begin
                out_port_reg <= in_data[3:0];
            end
        end
    end

    // Kept free of reset so the array maps onto plain RAM; reset only
    // suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && wr_mem) begin
            mem[ea] <= in_data;
        end
    end

    always_comb begin
        rd_data = mem[addr_reg];
        if (addr_reg == INPUT_PORT) begin
            rd_data = {{4{in_port_reg[3]}}, in_port_reg};
        end
    end

    // The output port is write-only, so its address never drives the bus.
    assign drive    = in_read_en && (addr_reg != OUTPUT_PORT);
    assign out_data = drive ? rd_data : 8'hzz;
    assign out_port = out_port_reg;

endmodule

// File: tb/tb_data_memory_manager.sv
// Self-checking bench for data_memory_manager: directed sequence with literal
// expectations followed by randomized traffic against a behavioural model.

module tb_data_memory_manager;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_write_en = 1'b0;
    logic       in_read_en = 1'b0;
    logic       in_addr_write_en = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [9:0] in_addr = 10'h000;
    logic [3:0] in_port = 4'h0;
    logic [3:0] out_port;

    // Pulled-up bus: an undriven (Z) bus reads as 8'hFF.
    tri1  [7:0] bus;

    int checks = 0;
    int failures = 0;
    bit run = 1'b0;

    // Behavioural model state
    logic [7:0] m_mem   [0:1023];
    bit         m_known [0:1023];
    logic [9:0] m_addr;
    logic [3:0] m_inp;
    logic [3:0] m_out;

    data_memory_manager dut (
        .clk              (clk),
        .rst              (rst),
        .in_write_en      (in_write_en),
        .in_read_en       (in_read_en),
        .in_addr_write_en (in_addr_write_en),
        .in_data          (in_data),
        .in_addr          (in_addr),
        .out_data         (bus),
        .in_port          (in_port),
        .out_port         (out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Apply inputs, take one rising edge, advance the model with the
    // inputs that were sampled on that edge.
    task automatic cyc(input bit r, input bit we, input bit re,
                       input bit awe, input logic [7:0] d,
                       input logic [9:0] a, input logic [3:0] p);
        logic [9:0] ea;
        rst = r;
        in_write_en = we;
        in_read_en = re;
        in_addr_write_en = awe;
        in_data = d;
        in_addr = a;
        in_port = p;
        @(posedge clk);
        if (r) begin
            m_addr = 10'd0;
            m_inp  = 4'd0;
            m_out  = 4'd0;
        end else begin
            ea = awe ? a : m_addr;
            if (we) begin
                if (ea == 10'h3FF) begin
                    m_out = d[3:0];
                end else if (ea != 10'h3FE) begin
                    m_mem[ea]   = d;
                    m_known[ea] = 1'b1;
                end
            end
            m_inp = p;
            if (awe) m_addr = a;
        end
        run = 1'b1;
        #2;
    endtask

    // Compare process: every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (run) begin
            chk("out_port", {4'h0, out_port}, {4'h0, m_out});
            if (!in_read_en || m_addr == 10'h3FF) begin
                chk("bus_z", bus, 8'hFF);
            end else if (m_addr == 10'h3FE) begin
                chk("bus_inport", bus, {{4{m_inp[3]}}, m_inp});
            end else if (m_known[m_addr]) begin
                chk("bus_mem", bus, m_mem[m_addr]);
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            m_mem[i]   = 8'h00;
`ifdef DATA_MEMORY_MANAGER_MEM_INIT_EN
            m_known[i] = 1'b1;
`else
            m_known[i] = 1'b0;
`endif
        end
        m_addr = 10'd0;
        m_inp  = 4'd0;
        m_out  = 4'd0;

        // Reset with a concurrent output-port write: reset wins.
        cyc(1, 1, 1, 1, 8'h8F, 10'h3FF, 4'h0);
        #1 chk("lit_rst_outport", {4'h0, out_port}, 8'h00);

        // Write path
        cyc(0, 1, 1, 1, 8'h99, 10'h3FE, 4'h0);
        #1 chk("lit_inport_zero", bus, 8'h00);
        cyc(0, 0, 1, 1, 8'h99, 10'h00F, 4'h0);
        cyc(0, 1, 1, 1, 8'h99, 10'h00F, 4'h0);
        #1 chk("lit_write_through", bus, 8'h99);

        // Read gating
        cyc(0, 0, 1, 1, 8'h99, 10'h3FF, 4'h0);
        #1 chk("lit_outport_unreadable", bus, 8'hFF);
        cyc(0, 0, 0, 1, 8'h99, 10'h00F, 4'h0);
        #1 chk("lit_read_en_off", bus, 8'hFF);
        in_read_en = 1'b1;
        #1 chk("lit_read_en_immediate", bus, 8'h99);
        cyc(0, 0, 1, 1, 8'h99, 10'h00F, 4'h0);
        #1 chk("lit_reread", bus, 8'h99);

        // Input port, sign extension and edge sampling
        cyc(0, 0, 1, 1, 8'h00, 10'h055, 4'hC);
        cyc(0, 0, 1, 1, 8'h00, 10'h3FE, 4'hC);
        #1 chk("lit_inport_sext", bus, 8'hFC);
        in_port = 4'h1;
        #1 chk("lit_inport_hold", bus, 8'hFC);
        cyc(0, 0, 1, 1, 8'h00, 10'h3FE, 4'h1);
        #1 chk("lit_inport_new", bus, 8'h01);

        // Output port
        cyc(0, 1, 1, 1, 8'h8C, 10'h055, 4'h1);
        #1 chk("lit_outport_hold", {4'h0, out_port}, 8'h00);
        chk("lit_mem_055", bus, 8'h8C);
        cyc(0, 1, 1, 1, 8'h8C, 10'h3FF, 4'h1);
        #1 chk("lit_outport_write", {4'h0, out_port}, 8'h0C);
        chk("lit_outport_z", bus, 8'hFF);

        // Reset with write, memory preserved
        cyc(1, 1, 1, 1, 8'h83, 10'h3FF, 4'h1);
        #1 chk("lit_rst_outport2", {4'h0, out_port}, 8'h00);
        cyc(0, 0, 1, 1, 8'h00, 10'h055, 4'h1);
        #1 chk("lit_mem_kept", bus, 8'h8C);

        // Address hold: write goes to the held address
        cyc(0, 0, 1, 1, 8'h00, 10'h00F, 4'h1);
        cyc(0, 1, 1, 0, 8'h5A, 10'h055, 4'h1);
        #1 chk("lit_hold_write", bus, 8'h5A);
        cyc(0, 0, 1, 1, 8'h00, 10'h055, 4'h1);
        #1 chk("lit_hold_other", bus, 8'h8C);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [9:0] a;
            bit r;
            case ($urandom_range(0, 3))
                0: a = 10'h3FE;
                1: a = 10'h3FF;
                2: a = 10'($urandom_range(0, 15));
                default: a = 10'($urandom);
            endcase
            r = ($urandom_range(0, 63) == 0);
            cyc(r, 1'($urandom), ($urandom_range(0, 7) != 0),
                1'($urandom), 8'($urandom_range(0, 254)), a,
                4'($urandom));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
